router_param: RTL

- Next-generation mesh router: 6 ports with a fixed channel map, parametrised flit width, coordinate width and input-buffer depth.
- Each input is buffered in a DEPTH-entry FIFO and routed dimension-order (X then Y, with a local/bound split).
- Each output has a round-robin switch allocator and wormhole locking from head to tail.
- Drop-in replacement for the current per-port router tile in the mesh; port channel ids are unchanged: 0 north, 1 west, 2 south, 3 east, 4 local, 5 bound.

---
 rtl/router_param_if.sv | 23 ++
 rtl/router_param.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/router_param_if.sv
// Six-channel flit bus between the mesh and one router tile.
// Channel c occupies bit c of each strobe and slice [c*DW +: DW] of each data bus.
interface router_param_if #(
    parameter int DW = 32
);
    logic [5:0]      valid_i;
    logic [6*DW-1:0] data_i;
    logic [5:0]      ready_o;
    logic [5:0]      valid_o;
    logic [6*DW-1:0] data_o;
    logic [5:0]      ready_i;
    logic [5:0]      drop_o;

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, drop_o
    );

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, drop_o
    );
endinterface

// File: rtl/router_param.sv
// Six-port mesh router: per-input FIFOs, XY route computation, and per-output
// round-robin allocation with wormhole locking from head to tail.
module router_param #(
    parameter int            DW         = 32,
    parameter int            CW         = 4,
    parameter int            DEPTH      = 4,
    parameter logic [CW-1:0] LocalRID_X = '0,
    parameter logic [CW-1:0] LocalRID_Y = '0
) (
    input logic           clk,
    input logic           rst,
    router_param_if.slave bus
);
    localparam int NP = 6;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_W = 3'd1,
        PORT_S = 3'd2,
        PORT_E = 3'd3,
        PORT_L = 3'd4,
        PORT_B = 3'd5
    } port_e;

    logic [DW-1:0] fifo_mem [NP][DEPTH];
    logic [AW:0]   wr_ptr_q [NP];
    logic [AW:0]   wr_ptr_d [NP];
    logic [AW:0]   rd_ptr_q [NP];
    logic [AW:0]   rd_ptr_d [NP];
    logic [NP-1:0] lock_vld_q, lock_vld_d;
    logic [2:0]    lock_src_q [NP];
    logic [2:0]    lock_src_d [NP];
    logic [2:0]    rr_ptr_q   [NP];
    logic [2:0]    rr_ptr_d   [NP];

    logic [NP-1:0] empty, full, is_head, is_tail, bound, stray, push, pop, xfer;
    logic [DW-1:0] front [NP];
    port_e         route [NP];
    logic [NP-1:0] req   [NP];

    function automatic port_e route_of(input logic [DW-1:0] f);
        logic [CW-1:0] dst_x;
        logic [CW-1:0] dst_y;
        logic          bnd;
        dst_x = f[DW-3 -: CW];
        dst_y = f[DW-3-CW -: CW];
        bnd   = f[DW-3-2*CW];
        if (dst_x > LocalRID_X) return PORT_E;
        if (dst_x < LocalRID_X) return PORT_W;
        if (dst_y > LocalRID_Y) return PORT_S;
        if (dst_y < LocalRID_Y) return PORT_N;
        return bnd ? PORT_B : PORT_L;
    endfunction

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin : input_side
        empty   = '0;
        full    = '0;
        is_head = '0;
        is_tail = '0;
        bound   = '0;
        stray   = '0;
        for (int i = 0; i < NP; i++) begin
            empty[i]   = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]    = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                         (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
            front[i]   = fifo_mem[i][rd_ptr_q[i][AW-1:0]];
            // Type bit DW-2 set means head or single; bit DW-1 set means tail or single.
            is_head[i] = !empty[i] && front[i][DW-2];
            is_tail[i] = front[i][DW-1];
            route[i]   = route_of(front[i]);
            for (int o = 0; o < NP; o++) begin
                if (lock_vld_q[o] && (lock_src_q[o] == 3'(i))) bound[i] = 1'b1;
            end
            stray[i]   = !empty[i] && !bound[i] && !front[i][DW-2];
        end
    end

    always_comb begin : requests
        for (int o = 0; o < NP; o++) begin
            req[o] = '0;
            for (int i = 0; i < NP; i++) begin
                req[o][i] = !lock_vld_q[o] && is_head[i] && !bound[i] &&
                            (route[i] == port_e'(o));
            end
        end
    end

    always_comb begin : switch_traversal
        bus.valid_o = '0;
        bus.data_o  = '0;
        xfer        = '0;
        pop         = stray;
        for (int o = 0; o < NP; o++) begin
            if (lock_vld_q[o]) begin
                bus.valid_o[o]         = !empty[lock_src_q[o]];
                bus.data_o[o*DW +: DW] = front[lock_src_q[o]];
                xfer[o]                = bus.valid_o[o] && bus.ready_i[o];
                if (xfer[o]) pop[lock_src_q[o]] = 1'b1;
            end
        end
    end

    always_comb begin : allocation
        logic grant_vld;
        int   grant;
        int   idx;
        grant_vld  = 1'b0;
        grant      = 0;
        idx        = 0;
        lock_vld_d = lock_vld_q;
        for (int o = 0; o < NP; o++) begin
            lock_src_d[o] = lock_src_q[o];
            rr_ptr_d[o]   = rr_ptr_q[o];
            if (lock_vld_q[o]) begin
                if (xfer[o] && is_tail[lock_src_q[o]]) lock_vld_d[o] = 1'b0;
            end else begin
                grant_vld = 1'b0;
                grant     = 0;
                for (int k = 0; k < NP; k++) begin
                    idx = (int'(rr_ptr_q[o]) + k) % NP;
                    if (!grant_vld && req[o][idx]) begin
                        grant_vld = 1'b1;
                        grant     = idx;
                    end
                end
                if (grant_vld) begin
                    lock_vld_d[o] = 1'b1;
                    lock_src_d[o] = 3'(grant);
                    rr_ptr_d[o]   = (grant == NP - 1) ? 3'd0 : 3'(grant + 1);
                end
            end
        end
    end

    always_comb begin : fifo_pointers
        push = bus.valid_i & ~full;
        for (int i = 0; i < NP; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + (AW+1)'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + (AW+1)'(pop[i]);
        end
    end

    assign bus.ready_o = ~full;
    assign bus.drop_o  = stray;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_vld_q <= '0;
            for (int i = 0; i < NP; i++) begin
                wr_ptr_q[i]   <= '0;
                rd_ptr_q[i]   <= '0;
                lock_src_q[i] <= '0;
                rr_ptr_q[i]   <= '0;
            end
        end else begin
            lock_vld_q <= lock_vld_d;
            for (int i = 0; i < NP; i++) begin
                wr_ptr_q[i]   <= wr_ptr_d[i];
                rd_ptr_q[i]   <= rd_ptr_d[i];
                lock_src_q[i] <= lock_src_d[i];
                rr_ptr_q[i]   <= rr_ptr_d[i];
            end
        end
    end

    // NOTE: FIFO storage is not reset; emptiness comes from the pointers, and data_o is zero while unlocked.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (push[i]) fifo_mem[i][wr_ptr_q[i][AW-1:0]] <= bus.data_i[i*DW +: DW];
        end
    end
endmodule
